// File: rtl/muldiv_if.sv
// muldiv_if: request and write-back handshake between the CPU and muldiv_seq
interface muldiv_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opB;
  logic [4:0]            rd;
  logic                  busy;
  logic                  stall;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  modport master (
    output start, op, opA, opB, rd, wb_ready,
    input  busy, stall, wb_valid, wb_rd, wb_data
  );
  modport slave (
    input  start, op, opA, opB, rd, wb_ready,
    output busy, stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: bit-serial MUL/MULHU/DIVU/REMU sequencer; MULDIV_EARLY_OUT_EN lets multiplies stop once the multiplier is exhausted
module muldiv_seq #(
  parameter int DATA_WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         r_state;
  logic [1:0]     r_op;
  logic [4:0]     r_rd;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   r_div;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_rem;
  logic           r_wb_valid;
  logic [4:0]     r_wb_rd;
  logic [W-1:0]   r_wb_data;
  logic [2*W-1:0] w_acc_nx;
  logic [W:0]     w_rem_sh;
  logic           w_ge;
  logic [W-1:0]   w_rem_nx;
  logic [W-1:0]   w_quo_nx;
  logic           w_last;
  logic           w_exit;
  logic           w_zero_div;
  logic           w_zero_mul;
  logic [W-1:0]   w_result;
  assign w_acc_nx   = r_mplier[0] ? r_acc + r_mcand : r_acc;
  assign w_rem_sh   = {r_rem, r_quo[W-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_div};
  assign w_rem_nx   = w_ge ? W'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[W-1:0];
  assign w_quo_nx   = {r_quo[W-2:0], w_ge};
  assign w_last     = r_cnt == CW'(W - 1);
  assign w_zero_div = bus.op[1] & ~|bus.opB;
`ifdef MULDIV_EARLY_OUT_EN
  assign w_exit     = w_last | (~r_op[1] & ~|r_mplier[W-1:1]);
  assign w_zero_mul = ~bus.op[1] & ~|bus.opB;
`else
  assign w_exit     = w_last;
  assign w_zero_mul = 1'b0;
`endif
  assign w_result = r_op == 2'b00 ? w_acc_nx[W-1:0]   :
                    r_op == 2'b01 ? w_acc_nx[2*W-1:W] :
                    r_op == 2'b10 ? w_quo_nx          : w_rem_nx;
  assign bus.busy     = r_state != IDLE;
  assign bus.stall    = bus.start | bus.busy;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_rd    = r_wb_rd;
  assign bus.wb_data  = r_wb_data;
  // Sequencer: capture in IDLE, iterate one bit per cycle in RUN, hold the result in DONE until written back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_op     <= bus.op;
          r_rd     <= bus.rd;
          r_cnt    <= '0;
          r_acc    <= '0;
          r_mcand  <= {{W{1'b0}}, bus.opA};
          r_mplier <= bus.opB;
          r_div    <= bus.opB;
          r_quo    <= bus.opA;
          r_rem    <= '0;
          if (w_zero_div | w_zero_mul) begin
            r_state    <= DONE;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= bus.rd;
            r_wb_data  <= w_zero_mul ? '0 : bus.op[0] ? bus.opA : '1;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc    <= w_acc_nx;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_nx;
          r_quo    <= w_quo_nx;
          if (w_exit) begin
            r_state    <= DONE;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_result;
          end
        end
        DONE: if (bus.wb_ready) begin
          r_state    <= IDLE;
          r_wb_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: vector table plus scoreboard checks of results, latency and handshake behaviour
module tb_muldiv_seq;
  localparam int W = 32;
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   rd;
    logic [W-1:0] want;
    int           hold;
  } vec_t;
  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  muldiv_if #(.DATA_WIDTH(W)) bus();
  muldiv_seq #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  exp_t sb[$];
  vec_t v[13];
  int   n_vec = 0;
  int   n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
    if (op[1] && b == 0) return 0;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
      return 0;
    end
`endif
    return W;
  endfunction
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] want, input int hold, input string nm);
    int lat;
    logic [W-1:0] held;
    exp_t e;
    sb.push_back('{rd, want});
    bus.op = op; bus.opA = a; bus.opB = b; bus.rd = rd; bus.start = 1'b1;
    #1;
    chk({nm, " stall_on_start"}, 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.opA = ~a; bus.opB = ~b; bus.op = ~op; bus.rd = ~rd;
    chk({nm, " busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.wb_valid && lat < W + 5) begin
      chk({nm, " stall_run"}, 64'(bus.stall), 64'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat(op, b)));
    held = bus.wb_data;
    for (int i = 0; i < hold; i++) begin
      bus.start = (i == 1);
      if (i == 1) begin bus.op = 2'b10; bus.opA = 32'd1234; bus.opB = 32'd1; bus.rd = 5'd31; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({nm, " hold_valid"}, 64'(bus.wb_valid), 64'd1);
      chk({nm, " hold_data"}, 64'(bus.wb_data), 64'(held));
      chk({nm, " hold_stall"}, 64'(bus.stall), 64'd1);
    end
    e = sb.pop_front();
    chk({nm, " data"}, 64'(bus.wb_data), 64'(e.data));
    chk({nm, " rd"}, 64'(bus.wb_rd), 64'(e.rd));
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    chk({nm, " idle_after"}, {62'd0, bus.busy, bus.wb_valid}, 64'd0);
    chk({nm, " stall_after"}, 64'(bus.stall), 64'd0);
    if (!bus.wb_valid && bus.busy) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    v[0]  = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42,         0};
    v[1]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd1,  32'hFFFFFFFE,   0};
    v[2]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd2,  32'h00000001,   0};
    v[3]  = '{2'b10, 32'd100,        32'd7,          5'd3,  32'd14,         0};
    v[4]  = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd2,          0};
    v[5]  = '{2'b10, 32'd5,          32'd0,          5'd6,  32'hFFFFFFFF,   0};
    v[6]  = '{2'b11, 32'd5,          32'd0,          5'd7,  32'd5,          0};
    v[7]  = '{2'b00, 32'd12345,      32'd0,          5'd8,  32'd0,          0};
    v[8]  = '{2'b10, 32'hFFFFFFFF,   32'd1,          5'd9,  32'hFFFFFFFF,   0};
    v[9]  = '{2'b11, 32'h12345678,   32'h100,        5'd10, 32'h78,         0};
    v[10] = '{2'b01, 32'h00010000,   32'h00010000,   5'd11, 32'd1,          0};
    v[11] = '{2'b10, 32'h80000000,   32'd3,          5'd12, 32'h2AAAAAAA,   5};
    v[12] = '{2'b11, 32'h80000000,   32'd3,          5'd13, 32'd2,          0};
    bus.start = 1'b0; bus.op = 2'b00; bus.opA = '0; bus.opB = '0; bus.rd = '0; bus.wb_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    chk("reset wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("reset wb_data", 64'(bus.wb_data), 64'd0);
    chk("reset wb_rd", 64'(bus.wb_rd), 64'd0);
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    chk("idle wb_ready ignored", {62'd0, bus.busy, bus.wb_valid}, 64'd0);
    for (int i = 0; i < 13; i++)
      run_op(v[i].op, v[i].a, v[i].b, v[i].rd, v[i].want, v[i].hold, $sformatf("vec%0d", i));
    bus.op = 2'b10; bus.opA = 32'd100; bus.opB = 32'd7; bus.rd = 5'd20; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun reset busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= bus.wb_valid | bus.busy;
    end
    chk("midrun reset no writeback", 64'(seen), 64'd0);
    run_op(2'b10, 32'd9, 32'd3, 5'd14, 32'd3, 0, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
